// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lsu_pkg
// Purpose  : Shared definitions for the load/store memory master:
//            access-size encoding, FSM state type and a size helper.
// Revision : 1.0  initial release
// ============================================================================
package lsu_pkg;

    // Access size encoding on i_req_size; 2'd3 is reserved and behaves as word.
    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        WAIT = 3'd2,
        WR   = 3'd3,
        RESP = 3'd4
    } state_t;

    // Word and the reserved encoding both have bit 1 set.
    function automatic logic is_word(input logic [1:0] size);
        return size[1];
    endfunction

endpackage : lsu_pkg
`default_nettype wire

// File: rtl/lsu_mem_master_align.sv
`default_nettype none
// ============================================================================
// Module   : lsu_align
// Purpose  : Combinational lane logic for the load/store master.
//            - Load path : select byte/half/word lane of i_word, sign- or
//                          zero-extend to 32 bits.
//            - Store path: merge right-justified i_wdata into i_word at the
//                          addressed lane (read-modify-write data).
// Ports    : i_word      memory word (read data / old word)
//            i_lo        byte offset addr[1:0]
//            i_size      access size (SZ_*; 3 treated as word)
//            i_unsigned  1 = zero-extend loads
//            i_wdata     store data, right-justified
//            o_ld_data   extended load result
//            o_st_word   merged word for the write-back
// Revision : 1.0  initial release
// ============================================================================
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_lo,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_ld_data,
    output logic [31:0] o_st_word
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte    = i_word[{i_lo, 3'b000} +: 8];
        w_half    = i_lo[1] ? i_word[31:16] : i_word[15:0];

        o_ld_data = i_word;
        o_st_word = i_wdata;
        case (i_size)
            SZ_BYTE: begin
                o_ld_data = {{24{~i_unsigned & w_byte[7]}}, w_byte};
                o_st_word = i_word;
                o_st_word[{i_lo, 3'b000} +: 8] = i_wdata[7:0];
            end
            SZ_HALF: begin
                o_ld_data = {{16{~i_unsigned & w_half[15]}}, w_half};
                o_st_word = i_word;
                o_st_word[{i_lo[1], 4'b0000} +: 16] = i_wdata[15:0];
            end
            default: begin
                o_ld_data = i_word;
                o_st_word = i_wdata;
            end
        endcase
    end

endmodule : lsu_align
`default_nettype wire

// File: rtl/lsu_mem_master.sv
`default_nettype none
// ============================================================================
// Module   : lsu_mem_master
// Purpose  : Load/store initiator for a word-wide synchronous data memory.
//            One request at a time; sub-word stores are read-modify-write.
//            Optional macro LSU_MISALIGN_TRAP_EN: misaligned half/word
//            requests respond with o_rsp_err=1 at cycle 1, no memory access.
// Ports    : i_clk/i_rst        clock, synchronous active-high reset
//            i_req_*/o_req_ready request handshake (sampled at accept only)
//            o_rsp_*            one-cycle response pulse, data, error
//            o_mem_*/i_mem_data memory word address, write data, strobes,
//                               read data (valid cycle after read strobe)
// Revision : 1.0  initial release
// ============================================================================
module lsu_mem_master
    import lsu_pkg::*;
#(
    parameter int W = 32,
    parameter int D = 8
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_req_valid,
    output logic         o_req_ready,
    input  logic         i_req_we,
    input  logic [1:0]   i_req_size,
    input  logic         i_req_unsigned,
    input  logic [31:0]  i_req_addr,
    input  logic [31:0]  i_req_wdata,
    output logic         o_rsp_valid,
    output logic [31:0]  o_rsp_rdata,
    output logic         o_rsp_err,
    output logic [D-1:0] o_mem_addr,
    output logic [W-1:0] o_mem_data,
    output logic         o_mem_read,
    output logic         o_mem_write,
    input  logic [W-1:0] i_mem_data
);

    state_t         r_state, w_next;
    logic           r_ready, r_rsp_valid, r_read, r_write;
    logic [31:0]    r_rdata;
    logic [D-1:0]   r_maddr;
    logic [W-1:0]   r_mdata;

    // Request fields captured at accept.
    logic           r_we, r_uns;
    logic [1:0]     r_size, r_lo;
    logic [31:0]    r_wdata;

    logic           w_accept, w_misalign;
    logic [31:0]    w_ld_data, w_st_word;

    // Address bits above the memory window are intentionally dropped.
    logic           w_unused;
    assign w_unused = &{1'b0, i_req_addr[31:D+2]};

    // r_ready is high only in IDLE, so it doubles as the accept qualifier.
    assign w_accept = i_req_valid & r_ready;

`ifdef LSU_MISALIGN_TRAP_EN
    logic r_err;
    assign w_misalign = ((i_req_size == SZ_HALF) & i_req_addr[0]) |
                        (is_word(i_req_size) & (i_req_addr[1:0] != 2'b00));
    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_err <= 1'b0;
        else if (r_state == IDLE && w_accept)
            r_err <= w_misalign;
    end
    assign o_rsp_err = r_err;
`else
    assign w_misalign = 1'b0;
    assign o_rsp_err  = 1'b0;
`endif

    lsu_align u_align (
        .i_word     (i_mem_data),
        .i_lo       (r_lo),
        .i_size     (r_size),
        .i_unsigned (r_uns),
        .i_wdata    (r_wdata),
        .o_ld_data  (w_ld_data),
        .o_st_word  (w_st_word)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_misalign)
                        w_next = RESP;
                    else if (i_req_we && is_word(i_req_size))
                        w_next = WR;
                    else
                        w_next = RD;
                end
            end
            RD:      w_next = WAIT;
            WAIT:    w_next = r_we ? WR : RESP;
            WR:      w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Strobes and handshake are decoded from the next state so that every
    // output is a flop that is valid for the whole state it belongs to.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_ready     <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_read      <= 1'b0;
            r_write     <= 1'b0;
            r_rdata     <= '0;
            r_maddr     <= '0;
            r_mdata     <= '0;
            r_we        <= 1'b0;
            r_uns       <= 1'b0;
            r_size      <= SZ_BYTE;
            r_lo        <= 2'b00;
            r_wdata     <= '0;
        end else begin
            r_state     <= w_next;
            r_ready     <= (w_next == IDLE);
            r_read      <= (w_next == RD);
            r_write     <= (w_next == WR);
            r_rsp_valid <= (w_next == RESP);

            if (r_state == IDLE && w_accept) begin
                r_we    <= i_req_we;
                r_uns   <= i_req_unsigned;
                r_size  <= i_req_size;
                r_lo    <= i_req_addr[1:0];
                r_wdata <= i_req_wdata;
                r_maddr <= i_req_addr[D+1:2];
                r_rdata <= '0;
                if (i_req_we && is_word(i_req_size))
                    r_mdata <= i_req_wdata;
            end

            if (r_state == WAIT) begin
                if (r_we)
                    r_mdata <= w_st_word;
                else
                    r_rdata <= w_ld_data;
            end
        end
    end

    assign o_req_ready = r_ready;
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_rdata = r_rdata;
    assign o_mem_addr  = r_maddr;
    assign o_mem_data  = r_mdata;
    assign o_mem_read  = r_read;
    assign o_mem_write = r_write;

endmodule : lsu_mem_master
`default_nettype wire

// File: doc/lsu_mem_master.md
# lsu_mem_master

Load/store initiator for the core's word-wide synchronous data memory. It accepts one byte, halfword or word request at a time from the execute stage and drives the memory's address, data, read and write strobes. It returns load data aligned and sign- or zero-extended. Sub-word stores are done as a read-modify-write of the containing word, because the memory has no byte enables.

## Interface
Parameters:
- W, 32, memory word width; must be 32.
- D, 8, memory word-address width; 2**D words.

Ports:
- i_clk  in  1  clock; all state changes on rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_req_valid  in  1  request present.
- o_req_ready  out  1  request accepted when valid && ready at the edge.
- i_req_we  in  1  1 = store, 0 = load.
- i_req_size  in  2  0 = byte, 1 = half, 2 = word; 3 is reserved and is treated as word.
- i_req_unsigned  in  1  loads: zero-extend (1) or sign-extend (0).
- i_req_addr  in  32  byte address.
- i_req_wdata  in  32  store data, right-justified.
- o_rsp_valid  out  1  one-cycle completion pulse; no backpressure.
- o_rsp_rdata  out  32  load result; 0 for stores.
- o_rsp_err  out  1  misaligned request (only with LSU_MISALIGN_TRAP_EN).
- o_mem_addr  out  D  word address to memory.
- o_mem_data  out  W  write data to memory.
- o_mem_read  out  1  memory read strobe.
- o_mem_write  out  1  memory write strobe.
- i_mem_data  in  W  memory read data, valid the cycle after o_mem_read is sampled.

## Operation
- All outputs are registered.
- Reset values: o_req_ready=1; all other outputs 0; FSM in IDLE.

FSM:
- IDLE: ready=1. On accept, latch the request and compute the word address as i_req_addr[D+1:2]. Upper address bits are ignored, so addresses wrap modulo 2**(D+2).
  - Load, or sub-word store → RD.
  - Word store → WR.
- RD: o_mem_read=1 for one cycle → WAIT.
- WAIT: i_mem_data is valid.
  - Load: select the lane from addr[1:0], extend, register into o_rsp_rdata → RESP.
  - Sub-word store: merge wdata into the read word at the lane → WR.
- WR: o_mem_write=1 with o_mem_data = merged word, or full wdata for a word store → RESP.
- RESP: o_rsp_valid=1 for one cycle → IDLE.

Lane rules:
- Byte lane k = addr[1:0] occupies bits [8k+7:8k].
- Half lane uses addr[1]: bits [15:0] or [31:16].
- Sign extension comes from the lane MSB.

Other rules:
- o_mem_read and o_mem_write are never high in the same cycle.
- o_mem_addr holds the latched value from accept until return to IDLE.
- Reset mid-operation: return to IDLE on that edge; strobes drop; no response; a partially completed RMW leaves memory unmodified.

## Timing
Accept edge = cycle 0. o_rsp_valid is high in:
- Word store: cycle 2.
- Load: cycle 3.
- Sub-word store: cycle 4.

Throughput and handshake:
- o_req_ready deasserts in cycle 1 and reasserts in the cycle after RESP.
- The next request can therefore be accepted on the edge ending the first IDLE cycle.
- i_req_* is sampled only at accept.

## Configuration
LSU_MISALIGN_TRAP_EN is defined:
- A half request with addr[0]=1, or a word request with addr[1:0]≠0, goes IDLE→RESP directly, with no memory strobe.
- The response is o_rsp_err=1 and o_rsp_rdata=0, at cycle 1.

LSU_MISALIGN_TRAP_EN is undefined:
- The low address bits below the access size are ignored: half uses addr[1]; word uses neither bit.
- o_rsp_err is tied to 0.

## Structure
- Package lsu_pkg holds:
  - the size encoding constants (SZ_BYTE, SZ_HALF, SZ_WORD);
  - the state enum (IDLE, RD, WAIT, WR, RESP).
- Sub-module lsu_align, purely combinational, holds:
  - load extract/extend: word, addr[1:0], size, unsigned → 32-bit result;
  - store merge: old word, wdata, addr[1:0], size → new word.
- The top level holds the FSM and registers; the bench instantiates it with the memory model.

## Test plan
- Word store 0xDEADBEEF at 0x10, then word load at 0x10 → o_mem_addr=4; rdata=0xDEADBEEF; rsp at cycles 2 and 3.
- After that, byte load at 0x13 signed → 0xFFFFFFDE; unsigned → 0x000000DE; half load at 0x12 signed → 0xFFFFDEAD.
- Byte store 0x55 at 0x11 → memory word 4 = 0xDEAD55EF; exactly one read then one write; rsp at cycle 4.
- Half load at 0x11:
  - with LSU_MISALIGN_TRAP_EN → err=1 at cycle 1, no strobes;
  - without → returns the half at 0x10.
- Assert i_rst during WAIT of a byte store → no write strobe, no rsp; ready=1 next cycle; memory unchanged.
- Address 0x400 (wraps, D=8) → o_mem_addr=0; back-to-back requests held valid are each accepted only in IDLE.
